// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 keyboard event receiver.
// Event layout matches ps2_key[9:0] from hps_io: {make, ext, code}.
package ps2_key_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;

    typedef struct packed {
        logic       make;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic {
        PRIME,
        RUN
    } state_t;

    // mods = {alt, ctrl, rshift, lshift}; shifts only count without the E0 prefix
    function automatic logic [3:0] next_mods(input logic [3:0] cur, input key_evt_t evt);
        logic [3:0] m;
        m = cur;
        if (evt.code == SC_LSHIFT && !evt.ext) m[0] = evt.make;
        if (evt.code == SC_RSHIFT && !evt.ext) m[1] = evt.make;
        if (evt.code == SC_CTRL)               m[2] = evt.make;
        if (evt.code == SC_ALT)                m[3] = evt.make;
        return m;
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Set-2 scancode to US ASCII translation; only present when KEY_ASCII_EN is defined.
// Unmapped codes return 0.
`ifdef KEY_ASCII_EN
module ps2_ascii_lut (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [15:0] pair;  // {unshifted, shifted}

    always_comb begin
        pair = '0;
        case (code)
            8'h1C: pair = "aA";
            8'h32: pair = "bB";
            8'h21: pair = "cC";
            8'h23: pair = "dD";
            8'h24: pair = "eE";
            8'h2B: pair = "fF";
            8'h34: pair = "gG";
            8'h33: pair = "hH";
            8'h43: pair = "iI";
            8'h3B: pair = "jJ";
            8'h42: pair = "kK";
            8'h4B: pair = "lL";
            8'h3A: pair = "mM";
            8'h31: pair = "nN";
            8'h44: pair = "oO";
            8'h4D: pair = "pP";
            8'h15: pair = "qQ";
            8'h2D: pair = "rR";
            8'h1B: pair = "sS";
            8'h2C: pair = "tT";
            8'h3C: pair = "uU";
            8'h2A: pair = "vV";
            8'h1D: pair = "wW";
            8'h22: pair = "xX";
            8'h35: pair = "yY";
            8'h1A: pair = "zZ";
            8'h16: pair = "1!";
            8'h1E: pair = "2@";
            8'h26: pair = "3#";
            8'h25: pair = "4$";
            8'h2E: pair = "5%";
            8'h36: pair = "6^";
            8'h3D: pair = "7&";
            8'h3E: pair = "8*";
            8'h46: pair = "9(";
            8'h45: pair = "0)";
            8'h0E: pair = "`~";
            8'h4E: pair = "-_";
            8'h55: pair = "=+";
            8'h54: pair = "[{";
            8'h5B: pair = "]}";
            8'h5D: pair = "\\|";
            8'h4C: pair = ";:";
            8'h52: pair = "'\"";
            8'h41: pair = ",<";
            8'h49: pair = ".>";
            8'h4A: pair = "/?";
            8'h29: pair = "  ";
            8'h5A: pair = {8'h0D, 8'h0D};
            8'h66: pair = {8'h08, 8'h08};
            8'h76: pair = {8'h1B, 8'h1B};
            default: pair = '0;
        endcase
        ascii = shift ? pair[7:0] : pair[15:8];
    end

endmodule
`endif

// File: rtl/ps2_key_rx.sv
// Receives toggle-strobed keyboard events, tracks modifiers and queues events in a
// show-ahead FIFO. Define KEY_ASCII_EN to store a translated ASCII byte per entry.
module ps2_key_rx
    import ps2_key_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      ps2_key,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [9:0]       rd_data,
    output logic [7:0]       rd_ascii,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       mods,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
`ifdef KEY_ASCII_EN
    localparam int unsigned ENTRY_W = 18;
`else
    localparam int unsigned ENTRY_W = 10;
`endif

    state_t             state;
    logic               tog_q;
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] wr_entry;
    key_evt_t           evt;
    logic               new_evt;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    assign count    = wr_ptr - rd_ptr;
    assign rd_valid = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign head     = mem[rd_ptr[AW-1:0]];
    assign rd_data  = rd_valid ? head[9:0] : '0;

`ifdef KEY_ASCII_EN
    logic [7:0] lut_ascii;

    // Shift state before this event is what applies to the key being translated
    ps2_ascii_lut u_lut (
        .code  (evt.code),
        .shift (mods[0] | mods[1]),
        .ascii (lut_ascii)
    );

    assign wr_entry = {((evt.make && !evt.ext) ? lut_ascii : 8'h00), evt};
    assign rd_ascii = rd_valid ? head[17:10] : '0;
`else
    assign wr_entry = evt;
    assign rd_ascii = '0;
`endif

    always_comb begin
        evt     = key_evt_t'(ps2_key[9:0]);
        new_evt = (state == RUN) && (ps2_key[10] != tog_q);
        pop     = rd_en && rd_valid;
        push_ok = new_evt && (!full || pop);
        drop    = new_evt && full && !pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PRIME;
            tog_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mods     <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                PRIME: begin
                    tog_q <= ps2_key[10];
                    state <= RUN;
                end
                RUN: begin
                    if (new_evt) begin
                        tog_q <= ps2_key[10];
                        mods  <= next_mods(mods, evt);
                    end
                end
                default: state <= PRIME;
            endcase
            if (push_ok) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop)     rd_ptr <= rd_ptr + CNT_W'(1);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: a table of single events plus hand-written
// sequences for fill/overflow, simultaneous push/pop and mid-operation reset.
module tb_ps2_key_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        rd_en;
    logic        rd_valid;
    logic [9:0]  rd_data;
    logic [7:0]  rd_ascii;
    logic [4:0]  count;
    logic [3:0]  mods;
    logic        overflow;
    logic        clr_ovf;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        tog   = 1'b1;

    typedef struct {
        logic [9:0] key;
        logic [3:0] mods;
        logic [7:0] ascii;
    } vec_t;

    vec_t vecs[20];

    ps2_key_rx #(.DEPTH(16), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ascii (rd_ascii),
        .count    (count),
        .mods     (mods),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] k, input logic rd, input logic clr);
        tog     = ~tog;
        ps2_key = {tog, k};
        rd_en   = rd;
        clr_ovf = clr;
        step();
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_ascii;

        vecs[0]  = '{10'h21C, 4'b0000, 8'h61};
        vecs[1]  = '{10'h212, 4'b0001, 8'h00};
        vecs[2]  = '{10'h21C, 4'b0001, 8'h41};
        vecs[3]  = '{10'h012, 4'b0000, 8'h00};
        vecs[4]  = '{10'h259, 4'b0010, 8'h00};
        vecs[5]  = '{10'h216, 4'b0010, 8'h21};
        vecs[6]  = '{10'h059, 4'b0000, 8'h00};
        vecs[7]  = '{10'h314, 4'b0100, 8'h00};
        vecs[8]  = '{10'h211, 4'b1100, 8'h00};
        vecs[9]  = '{10'h014, 4'b1000, 8'h00};
        vecs[10] = '{10'h111, 4'b0000, 8'h00};
        vecs[11] = '{10'h312, 4'b0000, 8'h00};
        vecs[12] = '{10'h01C, 4'b0000, 8'h00};
        vecs[13] = '{10'h229, 4'b0000, 8'h20};
        vecs[14] = '{10'h25A, 4'b0000, 8'h0D};
        vecs[15] = '{10'h207, 4'b0000, 8'h00};
        vecs[16] = '{10'h24E, 4'b0000, 8'h2D};
        vecs[17] = '{10'h212, 4'b0001, 8'h00};
        vecs[18] = '{10'h24E, 4'b0001, 8'h5F};
        vecs[19] = '{10'h012, 4'b0000, 8'h00};

        // Startup with a stale high toggle level
        reset   = 1'b1;
        ps2_key = 11'h400;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        chk("start_valid", 32'(rd_valid), 32'd0);
        chk("start_count", 32'(count), 32'd0);
        chk("start_mods", 32'(mods), 32'd0);
        chk("start_ovf", 32'(overflow), 32'd0);
        chk("start_data", 32'(rd_data), 32'd0);

        // Table: one event, check head/mods/ascii, then pop
        for (int i = 0; i < 20; i++) begin
`ifdef KEY_ASCII_EN
            exp_ascii = vecs[i].ascii;
`else
            exp_ascii = 8'h00;
`endif
            send(vecs[i].key, 1'b0, 1'b0);
            chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].key));
            chk($sformatf("vec%0d_mods", i), 32'(mods), 32'(vecs[i].mods));
            chk($sformatf("vec%0d_ascii", i), 32'(rd_ascii), 32'(exp_ascii));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'd1);
            pop();
            chk($sformatf("vec%0d_popped", i), 32'(rd_valid), 32'd0);
        end

        // Push and pop together on a non-full, non-empty FIFO
        send(10'h21C, 1'b0, 1'b0);
        send(10'h232, 1'b1, 1'b0);
        chk("pp_count", 32'(count), 32'd1);
        chk("pp_head", 32'(rd_data), 32'h232);
        pop();
        chk("pp_empty", 32'(count), 32'd0);

        // Fill with back-to-back events, then overflow
        for (int i = 0; i < 16; i++) send(10'h230 + 10'(i), 1'b0, 1'b0);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd0);
        send(10'h212, 1'b0, 1'b0);
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_mods", 32'(mods), 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        send(10'h012, 1'b0, 1'b1);
        chk("clr_vs_drop", 32'(overflow), 32'd1);
        chk("drop_mods_clr", 32'(mods), 32'd0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf2", 32'(overflow), 32'd0);
        chk("full_head", 32'(rd_data), 32'h230);

        // Full with simultaneous push and pop
        send(10'h255, 1'b1, 1'b0);
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("read%0d", i), 32'(rd_data), 32'h230 + 32'(i));
            pop();
        end
        chk("read_last", 32'(rd_data), 32'h255);
        pop();
        chk("drain_valid", 32'(rd_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // Read on empty
        pop();
        chk("under_count", 32'(count), 32'd0);
        chk("under_valid", 32'(rd_valid), 32'd0);

        // Mid-operation reset
        send(10'h212, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(10'h230 + 10'(i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_mods", 32'(mods), 32'd1);
        reset = 1'b1;
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mods", 32'(mods), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        reset = 1'b0;
        repeat (3) step();
        chk("post_rst_stale", 32'(count), 32'd0);
        send(10'h21C, 1'b0, 1'b0);
        chk("post_rst_one", 32'(count), 32'd1);
        repeat (3) step();
        chk("post_rst_still_one", 32'(count), 32'd1);
        chk("post_rst_data", 32'(rd_data), 32'h21C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Consumer end of the toggle-strobed 11-bit keyboard event bus driven by hps_io (`ps2_key`).
- Detects each new event, tracks modifier state and buffers events in a show-ahead FIFO.
- The bexkat core reads events through a valid/read handshake.
- Sits inside the bexkat core, next to the video block, in the `clk_sys` domain.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] toggles once per new event; [9] 1 = make, 0 = break; [8] extended (E0) prefix; [7:0] set-2 scancode.
- rd_en  in  1  pops the head entry; ignored when rd_valid=0.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  10  head entry as {make, ext, code}.
- rd_ascii  out  8  ASCII of the head entry; 0 without KEY_ASCII_EN.
- count  out  CNT_W  current occupancy.
- mods  out  4  {alt, ctrl, rshift, lshift}, live key-down state.
- overflow  out  1  sticky flag: an event was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, state PRIME.
- State machine, two states:
  - PRIME: sample ps2_key[10] into tog_q and go to RUN. No event is generated, so a toggle level that is stale at reset release is never read as a keypress.
  - RUN: event when ps2_key[10] != tog_q. Then update tog_q and latch ps2_key[9:0].
- Latency: event seen in cycle N → entry written at edge N+1 → rd_valid=1 and rd_data valid in cycle N+1 (show-ahead). mods update on the same edge.
- Modifier codes:
  - 0x12 non-ext → lshift.
  - 0x59 non-ext → rshift.
  - 0x14 → ctrl (ext or not).
  - 0x11 → alt (ext or not).
  - Make sets the bit, break clears it.
  - Modifier events are also pushed to the FIFO.
- FIFO:
  - Wrapping pointers, CNT_W bits wide; count = wr_ptr - rd_ptr.
  - Pop occurs when rd_en && rd_valid; the next head is visible the following cycle.
  - Full (count==DEPTH) with push and no pop: event dropped, overflow←1, mods still updated.
  - Full with push and pop in the same cycle: both happen, count unchanged, no overflow.
  - Empty with rd_en: no effect, count stays 0, no underflow.
  - Push and pop on a non-empty, non-full FIFO in the same cycle: count unchanged.
- clr_ovf and a new drop in the same cycle: overflow stays 1 (set wins).
- Reset asserted mid-operation: FIFO flushed, mods cleared, state returns to PRIME. In-flight events are lost.
- A toggle is detected once per edge. Back-to-back toggles on consecutive cycles each produce one event.

Optional Feature:
- Macro KEY_ASCII_EN.
- When defined:
  - At push time, the code plus (lshift|rshift) as they stood before this event are translated by the ASCII lookup.
  - Covered set: letters, digits, space, enter=0x0D, backspace=0x08, esc=0x1B, and US punctuation.
  - Unmapped codes, ext codes and break events give 0.
  - The result is stored alongside the entry (entry width 18) and presented on rd_ascii with the same timing as rd_data.
- When not defined:
  - No lookup logic; entry width 10.
  - rd_ascii tied to 0.

Decomposition:
- Package ps2_key_pkg holds:
  - the scancode constants SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_ALT=8'h11;
  - the typedef key_evt_t {make, ext, code[7:0]};
  - the state enum {PRIME, RUN}.
- One natural sub-module: ps2_ascii_lut, a combinational function of (code, shift) to 8-bit ASCII. Instantiated only under KEY_ASCII_EN.

Test Plan:
- Startup: reset with ps2_key[10]=1, release, hold 10 cycles → rd_valid=0, count=0.
- Single event: toggle [10] with [9:0]=10'h21C (make 'A') → one cycle later rd_valid=1, rd_data=10'h21C, count=1. With KEY_ASCII_EN, rd_ascii=8'h61. Pulse rd_en → rd_valid=0 next cycle.
- Shifted key: make 0x12, then make 0x1C → mods=4'b0001 after the first event. With KEY_ASCII_EN the second entry has rd_ascii=8'h41. Break 0x12 (10'h012) → mods=0.
- Fill and overflow: 17 events with DEPTH=16 and no reads → count=16, overflow=1, first 16 codes read back in order. Pulse clr_ovf → overflow=0.
- Full plus simultaneous push/pop: at count=16, toggle with rd_en=1 → count stays 16, overflow stays 0, new event is the last entry read out.
- Mid-operation reset: count=5, assert reset for 1 cycle → count=0, mods=0, rd_valid=0. The next toggle after PRIME yields exactly one entry.
